sprite_line_renderer: RTL and testbench

//  Writer side of the double-buffered sprite line buffer: draws one sprite row per job into the

---
 rtl/sprite_line_renderer_if.sv | 37 +++
 rtl/sprite_line_renderer.sv | 138 +++++++++++++
 tb/tb_sprite_line_renderer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_line_renderer_if.sv
// sprite_line_renderer_if: job, pixel-word and line-buffer port bundle of the sprite line renderer
interface sprite_line_renderer_if;
   logic        line_start;
   logic        job_valid;
   logic        job_ready;
   logic [9:0]  job_x;
   logic [1:0]  job_width;
   logic        job_8bpp;
   logic        job_hflip;
   logic [1:0]  job_z;
   logic [3:0]  job_pal_off;
   logic [3:0]  job_coll_mask;
   logic        data_valid;
   logic        data_ready;
   logic [31:0] data_word;
   logic [9:0]  lb_rd_idx;
   logic [15:0] lb_rd_data;
   logic [9:0]  lb_wr_idx;
   logic [15:0] lb_wr_data;
   logic        lb_wr_en;
   logic [3:0]  collision;
   logic        busy;

   modport master (
      output line_start, job_valid, job_x, job_width, job_8bpp, job_hflip, job_z,
             job_pal_off, job_coll_mask, data_valid, data_word, lb_rd_data,
      input  job_ready, data_ready, lb_rd_idx, lb_wr_idx, lb_wr_data, lb_wr_en,
             collision, busy
   );

   modport slave (
      input  line_start, job_valid, job_x, job_width, job_8bpp, job_hflip, job_z,
             job_pal_off, job_coll_mask, data_valid, data_word, lb_rd_data,
      output job_ready, data_ready, lb_rd_idx, lb_wr_idx, lb_wr_data, lb_wr_en,
             collision, busy
   );
endinterface

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: draws one sprite row per job into the line buffer with z-merge and collision tracking
module sprite_line_renderer #(
   parameter int LINE_WIDTH = 640
) (
   input logic                   clk,
   input logic                   rst,
   sprite_line_renderer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t      state_q, state_d;
   logic [9:0]  x_q;
   logic [1:0]  w_q;
   logic        bpp8_q;
   logic        hflip_q;
   logic [1:0]  z_q;
   logic [3:0]  pal_q;
   logic [3:0]  mask_q;
   logic [4:0]  words_q, words_d;
   logic [31:0] sh_q, sh_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [5:0]  pix_q, pix_d;
   logic        s1_v_q;
   logic [9:0]  s1_x_q;
   logic [7:0]  s1_col_q;
   logic [3:0]  collision_q;

   logic        accept;
   logic        issue;
   logic        take;
   logic [7:0]  raw;
   logic [7:0]  color;
   logic [9:0]  span;
   logic [9:0]  dest_x;
   logic        hit;
   logic [3:0]  old_mask;
   logic [1:0]  old_z;
   logic [15:0] merged;
   logic [3:0]  new_coll;
   logic        unused_rd_hi;

   assign accept          = bus.job_valid && state_q == IDLE;
   assign issue           = state_q == RUN && cnt_q != 4'd0;
   assign bus.data_ready  = state_q == RUN && words_q != 5'd0 && cnt_q <= 4'd1;
   assign take            = bus.data_valid && bus.data_ready;
   assign raw             = bpp8_q ? sh_q[31:24] : {4'b0, sh_q[31:28]};
   assign color           = raw[7:4] == 4'd0 ? {pal_q, raw[3:0]} : raw;
   assign span            = (10'd8 << w_q) - 10'd1;
   assign dest_x          = hflip_q ? x_q + span - {4'b0, pix_q} : x_q + {4'b0, pix_q};
   assign hit             = issue && raw != 8'd0 && int'(dest_x) < LINE_WIDTH && z_q != 2'd0;
   assign old_mask        = bus.lb_rd_data[13:10];
   assign old_z           = bus.lb_rd_data[9:8];
   assign unused_rd_hi    = ^bus.lb_rd_data[15:14];
   assign merged          = {2'b00, old_mask | mask_q,
                             z_q > old_z ? {z_q, s1_col_q} : bus.lb_rd_data[9:0]};
   assign new_coll        = s1_v_q ? old_mask & mask_q : 4'd0;
   assign bus.job_ready   = state_q == IDLE;
   assign bus.busy        = state_q != IDLE;
   assign bus.lb_rd_idx   = issue ? dest_x : 10'd0;
   assign bus.lb_wr_en    = s1_v_q;
   assign bus.lb_wr_idx   = s1_x_q;
   assign bus.lb_wr_data  = s1_v_q ? merged : 16'd0;
   assign bus.collision   = collision_q;

   // next-state: job accept, word load / pixel shift, and end-of-row detection
   always_comb begin
      state_d = state_q;
      words_d = words_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      pix_d   = pix_q;
      unique case (state_q)
         IDLE: begin
            state_d = accept ? RUN : IDLE;
            words_d = accept ? (bus.job_8bpp ? 5'd2 << bus.job_width : 5'd1 << bus.job_width) : words_q;
            cnt_d   = accept ? 4'd0 : cnt_q;
            pix_d   = accept ? 6'd0 : pix_q;
         end
         RUN: begin
            sh_d    = take ? bus.data_word : issue ? (bpp8_q ? sh_q << 8 : sh_q << 4) : sh_q;
            cnt_d   = take ? (bpp8_q ? 4'd4 : 4'd8) : issue ? cnt_q - 4'd1 : cnt_q;
            words_d = take ? words_q - 5'd1 : words_q;
            pix_d   = issue ? pix_q + 6'd1 : pix_q;
            state_d = issue && cnt_q == 4'd1 && words_q == 5'd0 ? DRAIN : RUN;
         end
         DRAIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // control state, shifter and latched job descriptor
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         words_q <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         pix_q   <= '0;
         x_q     <= '0;
         w_q     <= '0;
         bpp8_q  <= 1'b0;
         hflip_q <= 1'b0;
         z_q     <= '0;
         pal_q   <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         words_q <= words_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         pix_q   <= pix_d;
         if (accept) begin
            x_q     <= bus.job_x;
            w_q     <= bus.job_width;
            bpp8_q  <= bus.job_8bpp;
            hflip_q <= bus.job_hflip;
            z_q     <= bus.job_z;
            pal_q   <= bus.job_pal_off;
            mask_q  <= bus.job_coll_mask;
         end
      end
   end

   // read-to-write pipeline stage and collision accumulator (line_start clears before new bits)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         s1_x_q      <= '0;
         s1_col_q    <= '0;
         collision_q <= '0;
      end else begin
         s1_v_q      <= hit;
         s1_x_q      <= issue ? dest_x : s1_x_q;
         s1_col_q    <= issue ? color : s1_col_q;
         collision_q <= (bus.line_start ? 4'd0 : collision_q) | new_coll;
      end
   end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: randomized self-checking bench with a line-buffer model and sprite reference
module tb_sprite_line_renderer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sprite_line_renderer_if bus();
   sprite_line_renderer #(.LINE_WIDTH(640)) dut (.clk(clk), .rst(rst), .bus(bus));

   logic [15:0] lb_mem  [1024];
   logic [15:0] exp_mem [1024];
   logic [3:0]  exp_coll = '0;
   logic [31:0] wq [$];
   logic        clr = 1'b1;
   logic        poke_en = 1'b0;
   logic [9:0]  poke_idx = '0;
   logic [15:0] poke_val = '0;
   int          wr_cnt = 0;
   int          pass_cnt = 0;
   int          chk_cnt = 0;

   // line buffer: registered read, write on strobe, test-side clear/poke port
   always @(posedge clk) begin
      bus.lb_rd_data <= lb_mem[bus.lb_rd_idx];
      if (clr) begin
         for (int i = 0; i < 1024; i++) lb_mem[i] <= '0;
      end else if (poke_en) begin
         lb_mem[poke_idx] <= poke_val;
      end else if (bus.lb_wr_en) begin
         lb_mem[bus.lb_wr_idx] <= bus.lb_wr_data;
         wr_cnt <= wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic clear_lb();
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
   endtask

   task automatic poke(input logic [9:0] idx, input logic [15:0] val);
      @(negedge clk);
      poke_en = 1'b1;
      poke_idx = idx;
      poke_val = val;
      @(negedge clk) poke_en = 1'b0;
      exp_mem[idx] = val;
   endtask

   task automatic pulse_ls();
      @(negedge clk) bus.line_start = 1'b1;
      @(negedge clk) bus.line_start = 1'b0;
      exp_coll = '0;
   endtask

   task automatic model(input logic [9:0] jx, input logic [1:0] w, input logic b8, input logic hf,
                        input logic [1:0] z, input logic [3:0] pal, input logic [3:0] mk, output int nwr);
      int npix, ppw, raw, xi, col;
      logic [31:0] wd;
      logic [15:0] old;
      logic [3:0]  nm;
      npix = 8 << w;
      ppw = b8 ? 4 : 8;
      nwr = 0;
      for (int i = 0; i < npix; i++) begin
         wd = wq[i / ppw];
         raw = b8 ? int'((wd >> (24 - 8 * (i % ppw))) & 32'hFF) : int'((wd >> (28 - 4 * (i % ppw))) & 32'hF);
         xi = hf ? (int'(jx) + npix - 1 - i) % 1024 : (int'(jx) + i) % 1024;
         if (raw != 0 && xi < 640 && z != 0) begin
            col = raw < 16 ? int'(pal) * 16 + raw : raw;
            old = exp_mem[xi];
            nm = old[13:10] | mk;
            exp_mem[xi] = z > old[9:8] ? {2'b00, nm, z, 8'(col)} : {2'b00, nm, old[9:0]};
            exp_coll = exp_coll | (old[13:10] & mk);
            nwr++;
         end
      end
   endtask

   task automatic run_job(input logic [9:0] jx, input logic [1:0] w, input logic b8, input logic hf,
                          input logic [1:0] z, input logic [3:0] pal, input logic [3:0] mk, input bit gaps);
      int nwr, wr0, t, idx, diffs;
      bit fire;
      model(jx, w, b8, hf, z, pal, mk, nwr);
      wr0 = wr_cnt;
      @(negedge clk);
      bus.job_valid = 1'b1;
      bus.job_x = jx;
      bus.job_width = w;
      bus.job_8bpp = b8;
      bus.job_hflip = hf;
      bus.job_z = z;
      bus.job_pal_off = pal;
      bus.job_coll_mask = mk;
      t = 0;
      while (!bus.job_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk("job_accept_timeout", 32'(t), 32'd0);
      @(negedge clk) bus.job_valid = 1'b0;
      idx = 0;
      t = 0;
      while (idx < wq.size() && t < 2000) begin
         bus.data_valid = gaps ? $urandom_range(0, 2) != 0 : 1'b1;
         bus.data_word = wq[idx];
         fire = bus.data_valid && bus.data_ready;
         @(negedge clk);
         if (fire) idx++;
         t++;
      end
      bus.data_valid = 1'b0;
      if (idx < wq.size()) chk("feed_timeout", 32'(idx), 32'(wq.size()));
      t = 0;
      while (bus.busy && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("busy_end", 32'(bus.busy), 32'd0);
      diffs = 0;
      for (int i = 0; i < 1024; i++) if (lb_mem[i] !== exp_mem[i]) diffs++;
      chk("lb_contents_diffs", 32'(diffs), 32'd0);
      chk("wr_count", 32'(wr_cnt - wr0), 32'(nwr));
      chk("collision", 32'(bus.collision), 32'(exp_coll));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t, wr0, nw;
      logic [1:0] w;
      logic b8;
      bus.line_start = 1'b0;
      bus.job_valid = 1'b0;
      bus.job_x = '0;
      bus.job_width = '0;
      bus.job_8bpp = 1'b0;
      bus.job_hflip = 1'b0;
      bus.job_z = '0;
      bus.job_pal_off = '0;
      bus.job_coll_mask = '0;
      bus.data_valid = 1'b0;
      bus.data_word = '0;
      for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_job_ready", 32'(bus.job_ready), 32'd1);
      chk("rst_data_ready", 32'(bus.data_ready), 32'd0);
      chk("rst_wr_en", 32'(bus.lb_wr_en), 32'd0);
      chk("rst_rd_idx", 32'(bus.lb_rd_idx), 32'd0);
      chk("rst_wr_idx", 32'(bus.lb_wr_idx), 32'd0);
      chk("rst_wr_data", 32'(bus.lb_wr_data), 32'd0);
      chk("rst_collision", 32'(bus.collision), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;
      clr = 1'b0;

      wq = '{32'h1234_5678};
      run_job(10'd100, 2'd0, 1'b0, 1'b0, 2'd3, 4'd2, 4'd1, 1'b0);
      chk("plain_idx100", 32'(lb_mem[100]), 32'h0721);
      chk("plain_idx107", 32'(lb_mem[107]), 32'h0728);

      clear_lb();
      run_job(10'd100, 2'd0, 1'b0, 1'b1, 2'd3, 4'd2, 4'd1, 1'b0);
      chk("hflip_idx107", 32'(lb_mem[107]), 32'h0721);
      chk("hflip_idx100", 32'(lb_mem[100]), 32'h0728);

      clear_lb();
      wq = '{32'h00FF_0A00, 32'h0102_0304};
      run_job(10'd200, 2'd0, 1'b1, 1'b0, 2'd1, 4'd5, 4'd4, 1'b1);
      chk("b8_transparent", 32'(lb_mem[200]), 32'h0000);
      chk("b8_ff", 32'(lb_mem[201]), 32'h11FF);
      chk("b8_small", 32'(lb_mem[202]), 32'h115A);

      pulse_ls();
      poke(10'd10, 16'h0A55);
      wq = '{32'h1000_0000};
      run_job(10'd10, 2'd0, 1'b0, 1'b0, 2'd1, 4'd1, 4'd3, 1'b0);
      chk("zlow_keep", 32'(lb_mem[10]), 32'h0E55);
      chk("zlow_coll", 32'(bus.collision), 32'h2);
      pulse_ls();
      poke(10'd10, 16'h0A55);
      run_job(10'd10, 2'd0, 1'b0, 1'b0, 2'd3, 4'd1, 4'd3, 1'b1);
      chk("zhigh_win", 32'(lb_mem[10]), 32'h0F11);

      clear_lb();
      wq = '{32'h1111_1111};
      run_job(10'd1020, 2'd0, 1'b0, 1'b0, 2'd2, 4'd3, 4'd8, 1'b1);
      chk("wrap_1020_skip", 32'(lb_mem[1020]), 32'h0000);
      chk("wrap_idx3", 32'(lb_mem[3]), 32'h2231);

      wq = '{32'h1234_5678, 32'h9ABC_DEF1};
      run_job(10'd300, 2'd1, 1'b0, 1'b0, 2'd0, 4'd7, 4'd15, 1'b1);

      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 3) == 0) pulse_ls();
         wq.delete();
         w = 2'($urandom_range(0, 3));
         b8 = 1'($urandom_range(0, 1));
         nw = b8 ? 2 << w : 1 << w;
         for (int k = 0; k < nw; k++) wq.push_back($urandom);
         run_job(10'($urandom), w, b8, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
      end

      clear_lb();
      pulse_ls();
      poke(10'd48, 16'h0511);
      wr0 = wr_cnt;
      @(negedge clk);
      bus.job_valid = 1'b1;
      bus.job_x = 10'd48;
      bus.job_width = 2'd0;
      bus.job_8bpp = 1'b0;
      bus.job_hflip = 1'b0;
      bus.job_z = 2'd2;
      bus.job_pal_off = 4'd1;
      bus.job_coll_mask = 4'd1;
      @(negedge clk);
      bus.job_valid = 1'b0;
      bus.data_valid = 1'b1;
      bus.data_word = 32'h1111_1111;
      t = 0;
      while (wr_cnt - wr0 < 3 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("midrst_reached", 32'(wr_cnt - wr0 >= 3), 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_wr_en", 32'(bus.lb_wr_en), 32'd0);
      chk("midrst_job_ready", 32'(bus.job_ready), 32'd1);
      chk("midrst_collision", 32'(bus.collision), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      bus.data_valid = 1'b0;
      @(negedge clk);
      chk("midrst_wr_en_held", 32'(bus.lb_wr_en), 32'd0);
      rst = 1'b0;
      clear_lb();
      exp_coll = '0;
      wq = '{32'h0123_4567};
      run_job(10'd600, 2'd0, 1'b0, 1'b1, 2'd1, 4'd9, 4'd2, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
